int_log_n: RTL and testbench

- Iterative integer logarithm unit: computes floor(log_base(value)) by repeated multiplication of a running product.
- Inverse companion of the team's power-N exponentiation block; a value produced by that block can be fed back here to recover the exponent.
- Sits beside the arithmetic datapath blocks; driven by a controller through a start/done handshake.

---
 rtl/int_log_n.sv | 156 +++++++++++++++
 tb/tb_int_log_n.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/int_log_n.sv
`default_nettype none
// ============================================================================
// Module   : int_log_n
// Purpose  : Iterative floor(log_base(value)) by repeated multiplication of a
//            running product; start/done handshake. Optional remainder output
//            (value - base^exponent) when INT_LOG_REMAINDER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module int_log_n #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exponent,
    output logic             exact,
    output logic             err
`ifdef INT_LOG_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0]   c_two      = WIDTH'(2);
    localparam logic [WIDTH-1:0]   c_zero_w   = '0;
    localparam logic [2*WIDTH-1:0] c_prod_one = (2*WIDTH)'(1);
    localparam logic [EXP_W-1:0]   c_cnt_one  = EXP_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [2*WIDTH-1:0] r_prod;
    logic [EXP_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_base;
    logic [WIDTH-1:0]   r_value;
    logic [EXP_W-1:0]   r_exponent;
    logic               r_exact;
    logic               r_err;

    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_value_ext;
    logic               w_load_err;
    logic               w_stop;
    logic               w_hit;

    // Product is bounded by value*base < 2^(2*WIDTH), so the wide multiply never wraps.
    assign w_value_ext = {c_zero_w, r_value};
    assign w_prod_next = r_prod * {c_zero_w, r_base};
    assign w_stop      = (w_prod_next > w_value_ext);
    assign w_hit       = (r_prod == w_value_ext);
    assign w_load_err  = (base < c_two) || (value == c_zero_w);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = w_load_err ? S_DONE : S_ITER;
            S_ITER:  if (w_stop) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_LOAD:  busy = 1'b1;
            S_ITER:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod     <= '0;
            r_count    <= '0;
            r_base     <= '0;
            r_value    <= '0;
            r_exponent <= '0;
            r_exact    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_base  <= base;
                    r_value <= value;
                    r_prod  <= c_prod_one;
                    r_count <= '0;
                    if (w_load_err) begin
                        r_err      <= 1'b1;
                        r_exponent <= '0;
                        r_exact    <= 1'b0;
                    end else begin
                        r_err <= 1'b0;
                    end
                end
                S_ITER: begin
                    if (w_stop) begin
                        r_exponent <= r_count;
                        r_exact    <= w_hit;
                    end else begin
                        r_prod  <= w_prod_next;
                        r_count <= r_count + c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exponent = r_exponent;
    assign exact    = r_exact;
    assign err      = r_err;

`ifdef INT_LOG_REMAINDER_EN
    logic [WIDTH-1:0] r_remainder;

    // At the stopping step r_prod <= value, so the low half holds base^exponent exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remainder <= '0;
        end else if (r_state == S_LOAD && w_load_err) begin
            r_remainder <= '0;
        end else if (r_state == S_ITER && w_stop) begin
            r_remainder <= r_value - r_prod[WIDTH-1:0];
        end
    end

    assign remainder = r_remainder;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_log_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_log_n
// Purpose  : Scoreboard bench for int_log_n with directed, hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_log_n;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] base;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [2:0] exponent;
    logic       exact;
    logic       err;
`ifdef INT_LOG_REMAINDER_EN
    logic [7:0] remainder;
`endif

    int_log_n #(.WIDTH(8), .EXP_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .exponent (exponent),
        .exact    (exact),
        .err      (err)
`ifdef INT_LOG_REMAINDER_EN
        ,
        .remainder(remainder)
`endif
    );

    typedef struct {
        logic [2:0] exponent;
        logic       exact;
        logic       err;
        logic [7:0] rem;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   n_done = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                n_done++;
                check("busy_with_done", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: actual done=1 required no pulse (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("exponent", {29'd0, exponent}, {29'd0, e.exponent});
                    check("exact", {31'd0, exact}, {31'd0, e.exact});
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("done_latency", cyc, e.done_cyc);
`ifdef INT_LOG_REMAINDER_EN
                    check("remainder", {24'd0, remainder}, {24'd0, e.rem});
`endif
                end
            end
        end
    end

    // d = rising edges from the start-sampling edge to the edge that enters DONE
    task automatic run(input logic [7:0] b, input logic [7:0] v, input logic [2:0] ex,
                       input logic xa, input logic er, input logic [7:0] rm,
                       input int d, input bit disturb);
        exp_t e;
        int   target;
        int   bcnt;
        bit   got;
        target = n_done + 1;
        base   = b;
        value  = v;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        e.exponent = ex;
        e.exact    = xa;
        e.err      = er;
        e.rem      = rm;
        e.done_cyc = cyc + d;
        sb.push_back(e);
        bcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (busy) bcnt++;
            if (n_done >= target) got = 1'b1;
            else begin
                if (disturb && k == 1) begin
                    start = 1'b1;
                    base  = 8'd3;
                    value = 8'd80;
                end
                if (disturb && k == 2) start = 1'b0;
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL done_timeout: actual no done in 40 cycles required done (base=%0d value=%0d)", b, v);
        end
        check("busy_cycles", bcnt, d);
        @(negedge clk);
    endtask

    initial begin
        int nd;
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        value = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_exponent", {29'd0, exponent}, 32'd0);
        check("rst_exact", {31'd0, exact}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(8'd2,   8'd8,   3'd3, 1'b1, 1'b0, 8'd0,   5, 1'b0);
        run(8'd3,   8'd80,  3'd3, 1'b0, 1'b0, 8'd53,  5, 1'b0);
        run(8'd2,   8'd255, 3'd7, 1'b0, 1'b0, 8'd127, 9, 1'b0);
        run(8'd7,   8'd1,   3'd0, 1'b1, 1'b0, 8'd0,   2, 1'b0);
        run(8'd1,   8'd9,   3'd0, 1'b0, 1'b1, 8'd0,   1, 1'b0);
        run(8'd5,   8'd0,   3'd0, 1'b0, 1'b1, 8'd0,   1, 1'b0);
        run(8'd2,   8'd8,   3'd3, 1'b1, 1'b0, 8'd0,   5, 1'b1);
        run(8'd255, 8'd255, 3'd1, 1'b1, 1'b0, 8'd0,   3, 1'b0);

        // Abort mid-ITER; no scoreboard entry, so any done pulse is flagged
        base  = 8'd2;
        value = 8'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_exponent", {29'd0, exponent}, 32'd0);
        check("abort_exact", {31'd0, exact}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
`ifdef INT_LOG_REMAINDER_EN
        check("abort_remainder", {24'd0, remainder}, 32'd0);
`endif
        nd = n_done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_no_done", n_done, nd);
        @(negedge clk);

        run(8'd2, 8'd200, 3'd7, 1'b0, 1'b0, 8'd72, 9, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        check("total_done_pulses", n_done, 32'd9);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running required finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
